uart_transmitter: RTL and testbench

Serialises one byte per request into an asynchronous UART frame: start bit, data bits LSB first, optional parity bit, then one or two stop bits. It is the transmit end of the UART link and drives the serial line consumed by the UART receiver. An internal bit-period counter times every bit from the single system clock, so all logic is in one clock domain.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 43 ++++
 rtl/uart_transmitter.sv | 139 +++++++++++++
 tb/tb_uart_transmitter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, line level and parity helper
package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;

    // Narrower words are zero-extended by the caller; extra zeros leave the XOR unchanged.
    function automatic logic parity(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter flagging the last cycle of each serial bit
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk2,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = enable && !clear && (cnt_q == CNT_LAST);

    // Next count: held at 0 by clear, wraps to 0 after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk2) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART frame serialiser: start, data LSB first, parity, stop
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk2,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx,
    output logic              busy,
    output logic              donet
);

    localparam logic [3:0] DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    logic [2:0]        state_q,  state_d;
    logic [DATA_W-1:0] shreg_q,  shreg_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              parity_q, parity_d;
    logic              tx_q,     tx_d;
    logic              busy_q,   busy_d;
    logic              donet_q,  donet_d;
    logic              bit_end;

    // The timer is parked at 0 in IDLE, which also clears it on the acceptance edge.
    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk2   (clk2),
        .rst    (rst),
        .clear  (state_q == IDLE),
        .enable (state_q != IDLE),
        .bit_end(bit_end)
    );

    // Frame sequencing; tx_d is the line level for the state being entered so tx stays registered.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        donet_d   = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = LINE_IDLE;
                if (tx_start) begin
                    shreg_d   = tx_data;
                    parity_d  = parity(16'(tx_data), PARITY_ODD != 0);
                    bit_cnt_d = 4'd0;
                    state_d   = START;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 4'd0;
                    tx_d      = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = 4'd0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = LINE_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_d      = shreg_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    bit_cnt_d = 4'd0;
                    tx_d      = LINE_IDLE;
                end
            end
            STOP: begin
                tx_d = LINE_IDLE;
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d   = IDLE;
                        bit_cnt_d = 4'd0;
                        donet_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = LINE_IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame without a done pulse.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= 4'd0;
            parity_q  <= 1'b0;
            tx_q      <= LINE_IDLE;
            busy_q    <= 1'b0;
            donet_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            donet_q   <= donet_d;
        end
    end

    assign tx    = tx_q;
    assign busy  = busy_q;
    assign donet = donet_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - directed self-checking bench for uart_transmitter
module tb_uart_transmitter;

    logic       clk2 = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] data_a, data_b;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk2 = ~clk2;

    always @(posedge clk2) cyc <= cyc + 1;

    uart_transmitter #(
        .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk2(clk2), .rst(rst), .tx_start(start_a), .tx_data(data_a),
        .tx(tx_a), .busy(busy_a), .donet(done_a)
    );

    uart_transmitter #(
        .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_b (
        .clk2(clk2), .rst(rst), .tx_start(start_b), .tx_data(data_b),
        .tx(tx_b), .busy(busy_b), .donet(done_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the negedge just after the acceptance edge; bits[k] is the line level of bit period k.
    task automatic check_frame(input string name, input int sel, input logic [11:0] bits,
                               input int nbits, input int pulse_at, output int done_cyc);
        logic o_tx, o_busy, o_done;
        for (int i = 0; i < nbits * 4; i++) begin
            o_tx   = (sel == 1) ? tx_b   : tx_a;
            o_busy = (sel == 1) ? busy_b : busy_a;
            o_done = (sel == 1) ? done_b : done_a;
            check($sformatf("%s tx c%0d", name, i), 32'(o_tx), 32'(bits[i / 4]));
            check($sformatf("%s busy c%0d", name, i), 32'(o_busy), 32'd1);
            check($sformatf("%s donet c%0d", name, i), 32'(o_done), 32'd0);
            if (i == pulse_at) begin
                start_a = 1'b1;
                data_a  = 8'h3c;
            end
            if (i == pulse_at + 1) start_a = 1'b0;
            @(negedge clk2);
        end
        o_tx   = (sel == 1) ? tx_b   : tx_a;
        o_busy = (sel == 1) ? busy_b : busy_a;
        o_done = (sel == 1) ? done_b : done_a;
        check($sformatf("%s end tx", name), 32'(o_tx), 32'd1);
        check($sformatf("%s end busy", name), 32'(o_busy), 32'd0);
        check($sformatf("%s end donet", name), 32'(o_done), 32'd1);
        done_cyc = cyc;
    endtask

    initial begin
        int d1, d2, s1, s2, dummy;
        rst     = 1'b1;
        start_a = 1'b1;
        start_b = 1'b1;
        data_a  = 8'hff;
        data_b  = 8'hff;

        // Reset held with tx_start high.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2);
            check($sformatf("rst tx c%0d", i), 32'(tx_a), 32'd1);
            check($sformatf("rst busy c%0d", i), 32'(busy_a), 32'd0);
            check($sformatf("rst donet c%0d", i), 32'(done_a), 32'd0);
            check($sformatf("rst busy_b c%0d", i), 32'(busy_b), 32'd0);
        end
        rst     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk2);
        check("post-rst busy", 32'(busy_a), 32'd0);
        check("post-rst tx", 32'(tx_a), 32'd1);

        // Even parity 0xA5: 0,10100101,0,1 -> 0x54A.
        start_a = 1'b1;
        data_a  = 8'ha5;
        @(negedge clk2);
        start_a = 1'b0;
        data_a  = 8'h00;
        check_frame("a5", 0, 12'h54a, 11, 1000, dummy);
        @(negedge clk2);
        check("a5 donet drop", 32'(done_a), 32'd0);

        // Odd parity, two stops, 0x01: parity 0, frame 0xC02 over 12 periods.
        start_b = 1'b1;
        data_b  = 8'h01;
        @(negedge clk2);
        start_b = 1'b0;
        data_b  = 8'hee;
        check_frame("odd01", 1, 12'hc02, 12, 1000, dummy);
        @(negedge clk2);
        check("odd01 donet drop", 32'(done_b), 32'd0);

        // Back-to-back with tx_start held high: 0x00 then 0xFF.
        start_a = 1'b1;
        data_a  = 8'h00;
        @(negedge clk2);
        s1     = cyc;
        data_a = 8'hff;
        check_frame("b2b0", 0, 12'h400, 11, 1000, d1);
        @(negedge clk2);
        s2      = cyc;
        start_a = 1'b0;
        check_frame("b2bff", 0, 12'h5fe, 11, 1000, d2);
        check("b2b start gap", 32'(s2 - s1), 32'd45);
        check("b2b donet gap", 32'(d2 - d1), 32'd45);

        // Busy-ignore: 0x3C pulse at cycle 10 of an 0xA5 frame.
        @(negedge clk2);
        start_a = 1'b1;
        data_a  = 8'ha5;
        @(negedge clk2);
        start_a = 1'b0;
        check_frame("ign", 0, 12'h54a, 11, 10, dummy);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk2);
            check($sformatf("ign idle busy c%0d", i), 32'(busy_a), 32'd0);
            check($sformatf("ign idle donet c%0d", i), 32'(done_a), 32'd0);
        end

        // Mid-frame reset during data bit 3 of 0xFF.
        start_a = 1'b1;
        data_a  = 8'hff;
        @(negedge clk2);
        start_a = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk2);
        end
        check("mid d3 tx", 32'(tx_a), 32'd1);
        check("mid d3 busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(negedge clk2);
        check("mid rst tx", 32'(tx_a), 32'd1);
        check("mid rst busy", 32'(busy_a), 32'd0);
        check("mid rst donet", 32'(done_a), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk2);
            check($sformatf("mid after donet c%0d", i), 32'(done_a), 32'd0);
            check($sformatf("mid after tx c%0d", i), 32'(tx_a), 32'd1);
        end

        // Clean 0x55 frame after the abort: 0,10101010,0,1 -> 0x4AA.
        start_a = 1'b1;
        data_a  = 8'h55;
        @(negedge clk2);
        start_a = 1'b0;
        check_frame("x55", 0, 12'h4aa, 11, 1000, dummy);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
